// File: rtl/imem_loader.sv
// ============================================================================
// Module      : imem_loader
// Description : Boot-time instruction-memory loader. Parses a framed byte
//               stream (magic, 16-bit word count, little-endian payload,
//               XOR checksum), writes 32-bit words into instruction RAM and
//               holds the CPU in reset until a verified load completes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module imem_loader #(
    parameter int         ADDR_WIDTH = 10,
    parameter logic [7:0] MAGIC      = 8'hA5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [31:0]           wr_data,
    output logic                  cpu_rst_n,
    output logic                  done,
    output logic                  error
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEN_LO = 3'd1,
        S_LEN_HI = 3'd2,
        S_DATA   = 3'd3,
        S_CHECK  = 3'd4,
        S_DONE   = 3'd5,
        S_ERROR  = 3'd6
    } state_t;

    // Largest legal word count; counts above this cannot fit in the RAM.
    localparam logic [16:0] c_capacity = 17'd1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] c_addr_one = ADDR_WIDTH'(1);

    state_t                state_q,    state_d;
    logic [15:0]           len_q,      len_d;
    logic [15:0]           word_cnt_q, word_cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q,     addr_d;
    logic [1:0]            byte_idx_q, byte_idx_d;
    logic [23:0]           shift_q,    shift_d;
    logic [7:0]            csum_q,     csum_d;
    logic                  wr_en_q,    wr_en_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q,  wr_addr_d;
    logic [31:0]           wr_data_q,  wr_data_d;

    logic                  w_take;
    logic [15:0]           w_len;
    logic [31:0]           w_word;
    logic [15:0]           w_cnt_next;

    // Handshake and datapath helpers: the new byte completes the length or
    // the word on top of what was already captured.
    assign w_take     = in_valid && in_ready;
    assign w_len      = {in_data, len_q[7:0]};
    assign w_word     = {in_data, shift_q};
    assign w_cnt_next = word_cnt_q + 16'd1;

    // Status outputs are pure decodes of the registered state.
    assign in_ready  = (state_q != S_DONE) && (state_q != S_ERROR);
    assign done      = (state_q == S_DONE);
    assign cpu_rst_n = (state_q == S_DONE);
    assign error     = (state_q == S_ERROR);
    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;

    // Next-state and datapath update for each accepted byte.
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        word_cnt_d = word_cnt_q;
        addr_d     = addr_q;
        byte_idx_d = byte_idx_q;
        shift_d    = shift_q;
        csum_d     = csum_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;

        case (state_q)
            S_IDLE: begin
                // Anything other than the magic byte is silently consumed.
                if (w_take && (in_data == MAGIC)) begin
                    state_d = S_LEN_LO;
                end
            end

            S_LEN_LO: begin
                if (w_take) begin
                    len_d[7:0] = in_data;
                    state_d    = S_LEN_HI;
                end
            end

            S_LEN_HI: begin
                if (w_take) begin
                    len_d      = w_len;
                    word_cnt_d = 16'd0;
                    csum_d     = 8'd0;
                    byte_idx_d = 2'd0;
                    addr_d     = '0;
                    if ({1'b0, w_len} > c_capacity) begin
                        state_d = S_ERROR;
                    end else if (w_len == 16'd0) begin
                        state_d = S_CHECK;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end

            S_DATA: begin
                if (w_take) begin
                    shift_d    = w_word[31:8];
                    csum_d     = csum_q ^ in_data;
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        // Fourth byte: the word is complete, write it out.
                        wr_en_d    = 1'b1;
                        wr_addr_d  = addr_q;
                        wr_data_d  = w_word;
                        addr_d     = addr_q + c_addr_one;
                        word_cnt_d = w_cnt_next;
                        if (w_cnt_next == len_q) begin
                            state_d = S_CHECK;
                        end
                    end
                end
            end

            S_CHECK: begin
                if (w_take) begin
                    state_d = (in_data == csum_q) ? S_DONE : S_ERROR;
                end
            end

            S_DONE, S_ERROR: begin
                // Rearm for another frame; RAM contents are left untouched.
                if (start) begin
                    state_d = S_IDLE;
                    addr_d  = '0;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            len_q      <= 16'd0;
            word_cnt_q <= 16'd0;
            addr_q     <= '0;
            byte_idx_q <= 2'd0;
            shift_q    <= 24'd0;
            csum_q     <= 8'd0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= 32'd0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            word_cnt_q <= word_cnt_d;
            addr_q     <= addr_d;
            byte_idx_q <= byte_idx_d;
            shift_q    <= shift_d;
            csum_q     <= csum_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
        end
    end

endmodule

`default_nettype wire
